// File: rtl/wb_slave_mux.sv
// Wishbone B3 single-master to multi-slave mux.
// The master address is decoded once, in IDLE, against per-slave region codes.
// The selected slave is then strobed until one of these happens:
//   - the slave acks,
//   - the wait counter reaches TIMEOUT, which returns err,
//   - the master drops m_cyc_i, which aborts the transfer silently.
// An unmapped access terminates after one cycle, with either a zero-data ack or err.
// Ports:
//   clk_i, reset_i              clock, synchronous active-high reset
//   m_*_i / m_*_o               Wishbone master side (adr, dat, sel, we, cyc, stb / ack, err, dat)
//   s_adr_o..s_cyc_o            master signals broadcast to every slave
//   s_stb_o                     one-hot slave strobe
//   s_ack_i, s_dat_i            per-slave ack and read data (slave i at [i*DW +: DW])
//   err_adr_o, err_cnt_o        last errored address, saturating error count
module wb_slave_mux #(
  parameter int NSLAVES      = 4,
  parameter int AW           = 64,
  parameter int DW           = 16,
  parameter int DEC_HI       = 23,
  parameter int DEC_LO       = 20,
  parameter logic [NSLAVES*(DEC_HI-DEC_LO+1)-1:0] SLAVE_MAP = {4'hF, 4'h2, 4'h1, 4'h0},
  parameter int TIMEOUT      = 15,
  parameter int UNMAPPED_ERR = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [AW-1:0]         m_adr_i,
  input  logic [DW-1:0]         m_dat_i,
  input  logic [DW/8-1:0]       m_sel_i,
  input  logic                  m_we_i,
  input  logic                  m_cyc_i,
  input  logic                  m_stb_i,
  output logic                  m_ack_o,
  output logic                  m_err_o,
  output logic [DW-1:0]         m_dat_o,
  output logic [AW-1:0]         s_adr_o,
  output logic [DW-1:0]         s_dat_o,
  output logic [DW/8-1:0]       s_sel_o,
  output logic                  s_we_o,
  output logic                  s_cyc_o,
  output logic [NSLAVES-1:0]    s_stb_o,
  input  logic [NSLAVES-1:0]    s_ack_i,
  input  logic [NSLAVES*DW-1:0] s_dat_i,
  output logic [AW-1:0]         err_adr_o,
  output logic [7:0]            err_cnt_o
);

  localparam int RW   = DEC_HI - DEC_LO + 1;
  localparam int SELW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_UNMAP} state_t;

  state_t            r_state;
  logic [SELW-1:0]   r_sel;
  logic [7:0]        r_cnt;
  logic [AW-1:0]     r_err_adr;
  logic [7:0]        r_err_cnt;

  logic              w_hit;
  logic [SELW-1:0]   w_idx;
  logic              w_sel_ack;
  logic [DW-1:0]     w_sel_dat;
  logic              w_active;
  logic              w_timeout;

  assign s_adr_o   = m_adr_i;
  assign s_dat_o   = m_dat_i;
  assign s_sel_o   = m_sel_i;
  assign s_we_o    = m_we_i;
  assign s_cyc_o   = m_cyc_i;
  assign err_adr_o = r_err_adr;
  assign err_cnt_o = r_err_cnt;

  // Scan from the top down, so that the lowest matching index is the one left in w_idx.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (m_adr_i[DEC_HI:DEC_LO] == SLAVE_MAP[i*RW +: RW]) begin
        w_hit = 1'b1;
        w_idx = SELW'(i);
      end
    end
  end

  assign w_sel_ack = s_ack_i[r_sel];
  assign w_sel_dat = s_dat_i[int'(r_sel)*DW +: DW];
  // A dropped cycle or a pending reset suppresses any termination in this cycle.
  assign w_active  = m_cyc_i & ~reset_i;
  assign w_timeout = (r_cnt == TO_CNT);

  // Ack is checked before timeout, so an ack in the timeout cycle wins.
  always_comb begin
    m_ack_o = 1'b0;
    m_err_o = 1'b0;
    m_dat_o = '0;
    s_stb_o = '0;
    case (r_state)
      ST_BUSY: begin
        s_stb_o[r_sel] = 1'b1;
        if (w_active) begin
          if (w_sel_ack) begin
            m_ack_o = 1'b1;
            m_dat_o = w_sel_dat;
          end else if (w_timeout) begin
            m_err_o = 1'b1;
          end
        end
      end
      ST_UNMAP: begin
        if (w_active) begin
          if (UNMAPPED_ERR != 0) m_err_o = 1'b1;
          else                   m_ack_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_err_adr <= '0;
      r_err_cnt <= '0;
    end else begin
      if (m_err_o) begin
        r_err_adr <= m_adr_i;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            r_cnt <= '0;
            if (w_hit) begin
              r_state <= ST_BUSY;
              r_sel   <= w_idx;
            end else begin
              r_state <= ST_UNMAP;
            end
          end
        end
        ST_BUSY: begin
          if (!m_cyc_i || m_ack_o || m_err_o) r_state <= ST_IDLE;
          else                                r_cnt   <= r_cnt + 8'd1;
        end
        ST_UNMAP: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_mux.sv
// Directed bench for wb_slave_mux.
// u_dut uses the default parameters.
// u_dup maps slaves 1 and 2 to the same region and makes unmapped accesses return err.
module tb_wb_slave_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] adr = '0;
  logic [15:0] wdat = '0;
  logic [1:0]  sel = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [3:0]  s_ack = '0;
  logic [63:0] s_dat = '0;

  logic        m_ack, m_err, d_ack, d_err;
  logic [15:0] m_dat, d_dat, s_dat_o, d_s_dat_o;
  logic [63:0] s_adr, d_s_adr, err_adr, d_err_adr;
  logic [1:0]  s_sel, d_s_sel;
  logic        s_we, s_cyc, d_s_we, d_s_cyc;
  logic [3:0]  s_stb, d_s_stb;
  logic [7:0]  err_cnt, d_err_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int pulses;

  wb_slave_mux u_dut (
    .clk_i(clk), .reset_i(rst), .m_adr_i(adr), .m_dat_i(wdat), .m_sel_i(sel),
    .m_we_i(we), .m_cyc_i(cyc), .m_stb_i(stb), .m_ack_o(m_ack), .m_err_o(m_err),
    .m_dat_o(m_dat), .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel),
    .s_we_o(s_we), .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_ack_i(s_ack),
    .s_dat_i(s_dat), .err_adr_o(err_adr), .err_cnt_o(err_cnt)
  );

  wb_slave_mux #(.SLAVE_MAP(16'hF220), .UNMAPPED_ERR(1)) u_dup (
    .clk_i(clk), .reset_i(rst), .m_adr_i(adr), .m_dat_i(wdat), .m_sel_i(sel),
    .m_we_i(we), .m_cyc_i(cyc), .m_stb_i(stb), .m_ack_o(d_ack), .m_err_o(d_err),
    .m_dat_o(d_dat), .s_adr_o(d_s_adr), .s_dat_o(d_s_dat_o), .s_sel_o(d_s_sel),
    .s_we_o(d_s_we), .s_cyc_o(d_s_cyc), .s_stb_o(d_s_stb), .s_ack_i(s_ack),
    .s_dat_i(s_dat), .err_adr_o(d_err_adr), .err_cnt_o(d_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; s_ack = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start(input logic [63:0] a);
    @(negedge clk);
    adr = a; cyc = 1'b1; stb = 1'b1;
    #1;
  endtask

  task automatic finish_xfer();
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; s_ack = '0;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    #1;
    check("rst_stb",  64'(s_stb), 64'h0);
    check("rst_ack",  64'(m_ack), 64'h0);
    check("rst_err",  64'(m_err), 64'h0);
    check("rst_dat",  64'(m_dat), 64'h0);
    check("rst_ecnt", 64'(err_cnt), 64'h0);
    check("rst_eadr", err_adr, 64'h0);

    // Read from slave 1, which acks two cycles after its strobe rises
    wdat = 16'hA5A5; sel = 2'b11; we = 1'b0;
    start(64'h100004);
    check("rd1_decode_stb", 64'(s_stb), 64'h0);
    check("bcast_adr", s_adr, 64'h100004);
    check("bcast_dat", 64'(s_dat_o), 64'hA5A5);
    @(negedge clk); #1;
    check("rd1_stb", 64'(s_stb), 64'b0010);
    check("rd1_noack0", 64'(m_ack), 64'h0);
    @(negedge clk); #1;
    check("rd1_noack1", 64'(m_ack), 64'h0);
    @(negedge clk);
    s_ack = 4'b0010; s_dat[16 +: 16] = 16'hBEEF;
    #1;
    check("rd1_ack", 64'(m_ack), 64'h1);
    check("rd1_dat", 64'(m_dat), 64'hBEEF);
    check("rd1_err", 64'(m_err), 64'h0);
    finish_xfer();
    check("rd1_ack_drop", 64'(m_ack), 64'h0);
    check("rd1_dat_zero", 64'(m_dat), 64'h0);
    check("rd1_stb_idle", 64'(s_stb), 64'h0);

    // Slaves 1 and 2 share region 2 in u_dup, so slave 1 must win there; slave 2 acks with minimum latency
    do_reset();
    start(64'h2000A0);
    @(negedge clk);
    s_ack = 4'b0100; s_dat[32 +: 16] = 16'h1234; s_dat[16 +: 16] = 16'h5555;
    #1;
    check("s2_stb", 64'(s_stb), 64'b0100);
    check("s2_ack", 64'(m_ack), 64'h1);
    check("s2_dat", 64'(m_dat), 64'h1234);
    check("dup_lowest_stb", 64'(d_s_stb), 64'b0010);
    check("dup_other_ack_ignored", 64'(d_ack), 64'h0);
    finish_xfer();
    check("s2_ack_drop", 64'(m_ack), 64'h0);

    // Unmapped access: u_dut returns a zero-data ack, u_dup returns err
    do_reset();
    s_dat = 64'hFFFF_FFFF_FFFF_FFFF;
    start(64'h500000);
    check("unmap_decode_ack", 64'(m_ack), 64'h0);
    @(negedge clk); #1;
    check("unmap_ack", 64'(m_ack), 64'h1);
    check("unmap_dat", 64'(m_dat), 64'h0);
    check("unmap_noerr", 64'(m_err), 64'h0);
    check("unmap_stb", 64'(s_stb), 64'h0);
    check("dup_unmap_err", 64'(d_err), 64'h1);
    check("dup_unmap_noack", 64'(d_ack), 64'h0);
    finish_xfer();
    check("unmap_one_cycle", 64'(m_ack), 64'h0);
    check("dup_err_one_cycle", 64'(d_err), 64'h0);
    check("dup_ecnt", 64'(d_err_cnt), 64'h1);
    check("dup_eadr", d_err_adr, 64'h500000);
    check("unmap_ecnt_zero", 64'(err_cnt), 64'h0);

    // Timeout on slave 0 while slave 2 keeps acking (that ack must be ignored)
    do_reset();
    s_ack = 4'b0100;
    start(64'h0ABCDE);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk); #1;
      check($sformatf("to_wait%0d_stb", k), 64'(s_stb), 64'b0001);
      check($sformatf("to_wait%0d_ack", k), 64'(m_ack), 64'h0);
      check($sformatf("to_wait%0d_err", k), 64'(m_err), 64'h0);
    end
    @(negedge clk); #1;
    check("to_err", 64'(m_err), 64'h1);
    check("to_err_noack", 64'(m_ack), 64'h0);
    finish_xfer();
    check("to_err_pulse", 64'(m_err), 64'h0);
    check("to_stb_drop", 64'(s_stb), 64'h0);
    check("to_ecnt", 64'(err_cnt), 64'h1);
    check("to_eadr", err_adr, 64'h0ABCDE);

    // Ack in the same cycle the counter reaches TIMEOUT: the ack wins
    start(64'h012340);
    for (int k = 0; k < 15; k++) @(negedge clk);
    @(negedge clk);
    s_ack = 4'b0001; s_dat[0 +: 16] = 16'h0F0F;
    #1;
    check("to_edge_ack", 64'(m_ack), 64'h1);
    check("to_edge_noerr", 64'(m_err), 64'h0);
    check("to_edge_dat", 64'(m_dat), 64'h0F0F);
    finish_xfer();
    check("to_edge_ecnt", 64'(err_cnt), 64'h1);
    check("to_edge_stb", 64'(s_stb), 64'h0);

    // Reset asserted mid-BUSY, together with the selected slave's ack
    start(64'h100000);
    @(negedge clk); #1;
    check("rstb_stb", 64'(s_stb), 64'b0010);
    @(negedge clk);
    rst = 1'b1; s_ack = 4'b0010;
    #1;
    check("rstb_noack", 64'(m_ack), 64'h0);
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; s_ack = '0;
    #1;
    check("rstb_stb_idle", 64'(s_stb), 64'h0);
    check("rstb_ecnt", 64'(err_cnt), 64'h0);
    check("rstb_eadr", err_adr, 64'h0);

    // m_cyc_i dropped in the third BUSY cycle: abort with no termination
    start(64'h100000);
    @(negedge clk); #1;
    check("abort_stb", 64'(s_stb), 64'b0010);
    @(negedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    #1;
    check("abort_noack", 64'(m_ack), 64'h0);
    check("abort_noerr", 64'(m_err), 64'h0);
    @(negedge clk); #1;
    check("abort_idle_stb", 64'(s_stb), 64'h0);
    check("abort_idle_err", 64'(m_err), 64'h0);
    check("abort_ecnt", 64'(err_cnt), 64'h0);

    // 300 consecutive timeouts: the error count saturates at 255
    pulses = 0;
    @(negedge clk);
    adr = 64'h0; cyc = 1'b1; stb = 1'b1; s_ack = '0;
    for (int c = 0; c < 300 * 20 && pulses < 300; c++) begin
      @(negedge clk); #1;
      if (m_err) pulses++;
    end
    finish_xfer();
    check("sat_pulses", 64'(pulses), 64'd300);
    check("sat_ecnt", 64'(err_cnt), 64'd255);
    check("sat_dup_ecnt", 64'(d_err_cnt), 64'd255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_slave_mux.md
WB_SLAVE_MUX -- requirements
Module: wb_slave_mux

Interface
REQ-001 SHALL have parameter NSLAVES, default 4: number of slave channels (1..16).
REQ-002 SHALL have parameter AW, default 64: address width.
REQ-003 SHALL have parameter DW, default 16: data width, a multiple of 8; SW = DW/8.
REQ-004 SHALL have parameters DEC_HI, default 23, and DEC_LO, default 20: address field used for decode; RW = DEC_HI-DEC_LO+1.
REQ-005 SHALL have parameter SLAVE_MAP, default {4'hF,4'h2,4'h1,4'h0}: packed NSLAVES*RW region codes; slave i occupies bits [i*RW +: RW].
REQ-006 SHALL have parameter TIMEOUT, default 15: maximum wait cycles for a slave ack (1..255).
REQ-007 SHALL have parameter UNMAPPED_ERR, default 0: 1 means unmapped access returns err; 0 means ack with zero data.
REQ-008 clk_i  in  1  clock; all logic on rising edge.
REQ-009 reset_i  in  1  reset; synchronous, active-high.
REQ-010 m_adr_i  in  AW  master address.
REQ-011 m_dat_i  in  DW  master write data.
REQ-012 m_sel_i  in  SW  byte lane selects.
REQ-013 m_we_i, m_cyc_i, m_stb_i  in  1 each  Wishbone B3 master controls.
REQ-014 m_ack_o, m_err_o  out  1 each  transfer termination.
REQ-015 m_dat_o  out  DW  read data to master.
REQ-016 s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o  out  AW/DW/SW/1/1  broadcast to slaves, driven from the master inputs.
REQ-017 s_stb_o  out  NSLAVES  one-hot slave strobes.
REQ-018 s_ack_i  in  NSLAVES  slave acks; s_dat_i  in  NSLAVES*DW  slave read data, slave i at [i*DW +: DW].
REQ-019 err_adr_o  out  AW  address of the most recent err or timeout; err_cnt_o  out  8  saturating error count.

Function
REQ-020 SHALL implement FSM states IDLE, BUSY, UNMAP.
REQ-021 IDLE: m_cyc_i&m_stb_i SHALL register a decode of m_adr_i[DEC_HI:DEC_LO] against SLAVE_MAP; on a hit go to BUSY with a latched index sel; on a miss go to UNMAP.
REQ-022 Multiple SLAVE_MAP matches SHALL resolve to the lowest index.
REQ-023 BUSY: s_stb_o[sel] SHALL be 1 and all other bits 0; s_stb_o SHALL be all 0 in IDLE and UNMAP.
REQ-024 BUSY: m_ack_o SHALL equal s_ack_i[sel] combinationally and m_dat_o SHALL equal the sel slice of s_dat_i; the FSM goes to IDLE on ack.
REQ-025 Acks from slaves other than sel SHALL be ignored.
REQ-026 Minimum transfer latency SHALL be 2 cycles: a decode cycle, then an ack cycle; each back-to-back transfer re-enters IDLE.
REQ-027 The BUSY wait counter SHALL clear on entry and increment each cycle without ack.
REQ-028 When the counter reaches TIMEOUT without ack, m_err_o SHALL pulse 1 cycle, the FSM goes to IDLE, and s_stb_o drops that cycle.
REQ-029 An ack in the same cycle the counter reaches TIMEOUT SHALL win: ack is issued and no err.
REQ-030 UNMAP SHALL last 1 cycle: m_ack_o=1 with m_dat_o=0 if UNMAPPED_ERR=0, else m_err_o=1; then IDLE.
REQ-031 Every m_err_o pulse SHALL latch m_adr_i into err_adr_o and increment err_cnt_o, which saturates at 255.
REQ-032 m_cyc_i low in BUSY or UNMAP SHALL abort to IDLE next cycle with no ack or err, and SHALL NOT count as an error.
REQ-033 m_ack_o and m_err_o SHALL never both be 1; outside ack/err cycles both SHALL be 0 and m_dat_o SHALL be 0.

Reset
REQ-034 reset_i high at a clock edge SHALL force IDLE, counter 0, err_adr_o 0, err_cnt_o 0, s_stb_o 0, m_ack_o 0, m_err_o 0, from any state including mid-transfer.
REQ-035 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-036 Read adr 0x100004, slave1 acks 2 cycles after strobe with 0xBEEF -> s_stb_o=4'b0010 and m_ack_o for 1 cycle with m_dat_o=0xBEEF.
REQ-037 Access to adr 0x500000 (unmapped), UNMAPPED_ERR=0 then =1 -> 1-cycle ack with data 0, then 1-cycle err with err_cnt_o=1 and err_adr_o=0x500000.
REQ-038 Slave0 never acks, TIMEOUT=15 -> m_err_o exactly 15 cycles after BUSY entry, s_stb_o returns to 0; ack arriving on cycle 15 -> ack and no err.
REQ-039 Slave2 asserts ack while slave0 is selected -> no m_ack_o; counter continues.
REQ-040 m_cyc_i dropped in cycle 3 of BUSY, and reset_i asserted mid-BUSY -> IDLE next cycle with no ack or err; reset also clears err_cnt_o.
REQ-041 300 consecutive timeouts -> err_cnt_o saturates at 255.
